// File: rtl/i2c_video_slave.sv
// I2C slave for the DVI encoder configuration port: oversampled START/STOP
// decode, 7-bit address match, 256-byte register file with auto-increment pointer.
module i2c_video_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h76
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I2C_SCL_video,
    inout  wire        I2C_SDA_video,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        mem_we;
    logic [7:0]  mem_q [256];

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I2C_SCL_video};
            sda_sync_q <= {sda_sync_q[0], I2C_SDA_video};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & ~sda_s & sda_prev_q;
    assign stop_det  = scl_s & sda_s & ~sda_prev_q;
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        if (start_det) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                    state_d = ADDR_ACK;
                                end else begin
                                    busy_d  = 1'b0;
                                    state_d = WAIT;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte;
                                state_d = PTR_ACK;
                            end else begin
                                mem_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_q + 8'd1;
                                state_d    = WDATA_ACK;
                            end
                        end
                    end
                end
                // cnt 0: 8th falling edge starts the ACK; cnt 1: 9th ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            oe_d  = 1'b1;
                            cnt_d = 4'd1;
                        end else begin
                            cnt_d   = 4'd0;
                            oe_d    = 1'b0;
                            state_d = WDATA;
                            if (state_q == ADDR_ACK) begin
                                if (rw_q) begin
                                    tx_d    = mem_q[ptr_q];
                                    oe_d    = ~mem_q[ptr_q][7];
                                    state_d = RDATA;
                                end else begin
                                    state_d = PTR;
                                end
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            ptr_d   = ptr_q + 8'd1;
                            state_d = RDATA_ACK;
                        end else begin
                            tx_d = {tx_q[6:0], tx_q[7]};
                            oe_d = ~tx_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) cnt_d = 4'd1;
                        else        state_d = WAIT;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = 4'd0;
                        tx_d    = mem_q[ptr_q];
                        oe_d    = ~mem_q[ptr_q][7];
                        state_d = RDATA;
                    end
                end
                IDLE, WAIT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    // Open drain: only ever pull low or release.
    assign I2C_SDA_video = oe_q ? 1'b0 : 1'bz;
    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_i2c_video_slave.sv
// Directed I2C master bench for i2c_video_slave with a write-strobe scoreboard
// and a register-file model for read-back expectations.
module tb_i2c_video_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda_bus;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data;
    logic       busy;
    logic [3:0] dbg_state;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_video_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .I2C_SCL_video(scl),
        .I2C_SDA_video(sda_bus),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr = 8'h00;
    int n_vec = 0, n_err = 0, n_push = 0, n_strb = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-strobe monitor: every pulse must match the oldest pushed write.
    always @(negedge clk) begin
        if (rst_n && wr_valid === 1'b1) begin
            n_strb++;
            check("strobe_pending", 16'(exp_q.size()), 16'd1);
            if (exp_q.size() > 0) check("strobe_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b;
        clk_wait(5); scl = 1'b1;
        clk_wait(10); scl = 1'b0;
        clk_wait(5);
    endtask

    task automatic recv_bit(output logic b);
        sda_low = 1'b0;
        clk_wait(5); scl = 1'b1;
        clk_wait(5); b = sda_bus;
        clk_wait(5); scl = 1'b0;
        clk_wait(5);
    endtask

    task automatic i2c_start;
        sda_low = 1'b0;
        clk_wait(5); scl = 1'b1;
        clk_wait(10); sda_low = 1'b1;
        clk_wait(10); scl = 1'b0;
        clk_wait(5);
    endtask

    task automatic i2c_stop;
        sda_low = 1'b1;
        clk_wait(5); scl = 1'b1;
        clk_wait(10); sda_low = 1'b0;
        clk_wait(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic send_acked(input string tag, input logic [7:0] b);
        logic ack;
        send_byte(b, ack);
        check(tag, {15'd0, ack}, 16'd0);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        send_acked("ptr_ack", p);
        model_ptr = p;
    endtask

    task automatic write_data(input logic [7:0] b);
        exp_q.push_back({model_ptr, b});
        n_push++;
        model_mem[model_ptr] = b;
        model_ptr = model_ptr + 8'd1;
        send_acked("data_ack", b);
    endtask

    task automatic read_data(input string tag, input logic nack);
        logic [7:0] d;
        logic       b;
        rd_q.push_back(model_mem[model_ptr]);
        model_ptr = model_ptr + 8'd1;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(nack);
        check(tag, {8'd0, d}, {8'd0, rd_q.pop_front()});
    endtask

    initial begin
        logic ack;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        // Reset state
        clk_wait(4);
        check("rst_sda", {15'd0, sda_bus}, 16'd1);
        check("rst_wr_valid", {15'd0, wr_valid}, 16'd0);
        check("rst_wr_addr", {8'd0, wr_addr}, 16'd0);
        check("rst_wr_data", {8'd0, wr_data}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        clk_wait(10);
        check("rst_state_idle", {12'd0, dbg_state}, 16'd0);

        // Read straight after reset: pointer starts at 0
        i2c_start;
        send_acked("addr_rd_ack", 8'hED);
        check("busy_after_addr", {15'd0, busy}, 16'd1);
        read_data("rd_after_reset0", 1'b0);
        read_data("rd_after_reset1", 1'b1);
        check("sda_free_after_nack", {15'd0, sda_bus}, 16'd1);
        i2c_stop;
        clk_wait(5);
        check("busy_after_stop", {15'd0, busy}, 16'd0);

        // Single write, then a second location for read-back
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h49); write_data(8'hC0); i2c_stop;
        clk_wait(5);
        check("busy_after_wr_stop", {15'd0, busy}, 16'd0);
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h4A); write_data(8'h3C); i2c_stop;

        // Burst write across the 0xFF -> 0x00 wrap
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'hFE);
        write_data(8'h11); write_data(8'h22); write_data(8'h33);
        i2c_stop;

        // Pointer write, repeated START, two-byte read
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h49);
        i2c_start; send_acked("addr_rd_ack", 8'hED);
        read_data("rd_49", 1'b0);
        read_data("rd_4a", 1'b1);
        check("sda_free_after_nack2", {15'd0, sda_bus}, 16'd1);
        i2c_stop;

        // Read across the wrap
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'hFF);
        i2c_start; send_acked("addr_rd_ack", 8'hED);
        read_data("rd_ff", 1'b0);
        read_data("rd_00", 1'b1);
        i2c_stop;

        // Foreign address: NACK, no strobes, bus stays usable
        i2c_start;
        send_byte(8'hA0, ack);
        check("foreign_addr_nack", {15'd0, ack}, 16'd1);
        check("foreign_busy", {15'd0, busy}, 16'd0);
        send_byte(8'hAA, ack);
        check("foreign_data_nack", {15'd0, ack}, 16'd1);
        i2c_stop;
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h05); write_data(8'h77); i2c_stop;
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h05);
        i2c_start; send_acked("addr_rd_ack", 8'hED);
        read_data("rd_05", 1'b1);
        i2c_stop;

        // Reset while the data-byte ACK is on the bus
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h10);
        exp_q.push_back({model_ptr, 8'h99});
        n_push++;
        for (int i = 7; i >= 0; i--) send_bit(((8'h99 >> i) & 8'h01) != 8'h00);
        sda_low = 1'b0;
        check("ack_before_reset", {15'd0, sda_bus}, 16'd0);
        rst_n = 1'b0;
        #1;
        check("sda_released_on_reset", {15'd0, sda_bus}, 16'd1);
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_ptr = 8'h00;
        clk_wait(3); scl = 1'b1;
        clk_wait(5); rst_n = 1'b1;
        clk_wait(10);
        check("busy_after_reset", {15'd0, busy}, 16'd0);
        i2c_start; send_acked("addr_rd_ack", 8'hED);
        read_data("rd_00_cleared", 1'b1);
        i2c_stop;
        i2c_start; send_acked("addr_wr_ack", 8'hEC); set_ptr(8'h10);
        i2c_start; send_acked("addr_rd_ack", 8'hED);
        read_data("rd_10_cleared", 1'b1);
        i2c_stop;

        clk_wait(10);
        check("strobe_count", 16'(n_strb), 16'(n_push));
        check("strobe_leftover", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
